// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared types, saturating score helpers and mode enum for the SW affine PE
package sw_pkg;

    localparam int SW_SCORE_W = 12;
    localparam int SW_SYM_W   = 2;

    typedef logic signed [SW_SCORE_W-1:0] score_t;
    typedef logic [SW_SYM_W-1:0]          sym_t;
    typedef logic signed [31:0]           wide_t;

    localparam score_t SMIN = {1'b1, {(SW_SCORE_W-1){1'b0}}};
    localparam score_t SMAX = {1'b0, {(SW_SCORE_W-1){1'b1}}};

    typedef enum logic {SW_LOCAL, SW_SEMIGLOBAL} sw_mode_e;

    function automatic wide_t smin_of(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

    function automatic wide_t smax_of(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    // Operands are sign-extended scores of width w; the result is clamped to that width's range,
    // so SMIN plus any negative value stays SMIN.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
        logic signed [32:0] sum;
        logic signed [32:0] lo;
        logic signed [32:0] hi;
        wide_t              lo_w;
        wide_t              hi_w;
        lo_w = smin_of(w);
        hi_w = smax_of(w);
        lo   = {lo_w[31], lo_w};
        hi   = {hi_w[31], hi_w};
        sum  = {a[31], a} + {b[31], b};
        if (sum > hi) return hi_w;
        if (sum < lo) return lo_w;
        return sum[31:0];
    endfunction

    // Strict compares keep the earliest argument on a tie.
    function automatic wide_t max3(input wide_t a, input wide_t b, input wide_t c);
        wide_t m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    function automatic sw_mode_e mode_of(input logic local_mode);
        return local_mode ? SW_LOCAL : SW_SEMIGLOBAL;
    endfunction

endpackage

// File: rtl/sw_affine_pe_tracked_if.sv
// rtl/sw_affine_pe_tracked_if.sv - PE-to-PE systolic link: scores, reference, control and readout chain
interface sw_affine_pe_tracked_if #(
    parameter int SCORE_W = 12,
    parameter int SYM_W   = 2,
    parameter int POS_W   = 16
);
    logic signed [SCORE_W-1:0] v;
    logic signed [SCORE_W-1:0] f;
    logic [SYM_W-1:0]          t;
    logic                      store_s;
    logic                      init;
    logic signed [SCORE_W-1:0] best;
    logic [POS_W-1:0]          best_pos;
    logic [15:0]               best_pe;
    logic                      best_valid;

    modport master (output v, f, t, store_s, init, best, best_pos, best_pe, best_valid);
    modport slave  (input  v, f, t, store_s, init, best, best_pos, best_pe, best_valid);
endinterface

// File: rtl/sw_best_tracker.sv
// rtl/sw_best_tracker.sv - reference position counter, per-PE best hit and readout chain stage
module sw_best_tracker
    import sw_pkg::*;
#(
    parameter int SCORE_W = 12,
    parameter int POS_W   = 16,
    parameter int PE_ID   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      compute,
    input  logic                      rise,
    input  logic signed [SCORE_W-1:0] h_next,
    sw_affine_pe_tracked_if.slave     up,
    sw_affine_pe_tracked_if.master    dn
);
    typedef logic signed [SCORE_W-1:0] sc_t;
    localparam sc_t             SC_MIN  = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [POS_W-1:0] POS_MAX = '1;

    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_cur;
    logic [POS_W-1:0] own_pos_q;
    sc_t              own_best_q;
    sc_t              best_cur;

    // The first compute cycle of a run sees a freshly cleared counter and best.
    assign pos_cur  = rise ? '0 : pos_q;
    assign best_cur = rise ? SC_MIN : own_best_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q         <= '0;
            own_best_q    <= SC_MIN;
            own_pos_q     <= '0;
            dn.best       <= '0;
            dn.best_pos   <= '0;
            dn.best_pe    <= '0;
            dn.best_valid <= 1'b0;
        end else begin
            if (compute) begin
                pos_q <= (pos_cur == POS_MAX) ? pos_cur : pos_cur + POS_W'(1);
                if (h_next > best_cur) begin
                    own_best_q <= h_next;
                    own_pos_q  <= pos_cur;
                end else begin
                    own_best_q <= best_cur;
                    if (rise) own_pos_q <= '0;
                end
            end
            dn.best_valid <= up.best_valid;
            // Incoming hit wins ties so the lower PE index survives the chain.
            if (up.best_valid) begin
                if (own_best_q > up.best) begin
                    dn.best     <= own_best_q;
                    dn.best_pos <= own_pos_q;
                    dn.best_pe  <= 16'(PE_ID);
                end else begin
                    dn.best     <= up.best;
                    dn.best_pos <= up.best_pos;
                    dn.best_pe  <= up.best_pe;
                end
            end
        end
    end
endmodule

// File: rtl/sw_affine_pe_tracked.sv
// rtl/sw_affine_pe_tracked.sv - Smith-Waterman affine-gap systolic PE with saturating scores and best tracking
module sw_affine_pe_tracked
    import sw_pkg::*;
#(
    parameter int SCORE_W    = 12,
    parameter int SYM_W      = 2,
    parameter int POS_W      = 16,
    parameter int PE_ID      = 0,
    parameter int MATCH      = 2,
    parameter int MISMATCH   = -2,
    parameter int GAP_OPEN   = -2,
    parameter int GAP_EXTEND = -1
) (
    input  logic                   clk,
    input  logic                   rst,
    sw_affine_pe_tracked_if.slave  up,
    sw_affine_pe_tracked_if.master dn,
    input  logic [SYM_W-1:0]       s_in,
    input  logic                   local_mode
);
    typedef logic signed [SCORE_W-1:0] sc_t;
    localparam wide_t LO = smin_of(SCORE_W);

    logic [SYM_W-1:0] s_q;
    sc_t              e_q;
    sc_t              diag_q;
    sw_mode_e         mode_q;

    logic     rise;
    sw_mode_e mode_now;
    wide_t    e_nx;
    wide_t    f_nx;
    wide_t    m_nx;
    wide_t    h_nx;
    wide_t    floor_v;
    sc_t      h_next;
    sc_t      e_next;
    sc_t      f_next;
    sc_t      idle_ef;

    assign rise = up.init && !dn.init;

    always_comb begin
        // On the rising edge the live mode applies; afterwards the latched one.
        mode_now = rise ? mode_of(local_mode) : mode_q;
        e_nx     = max3(sat_add(wide_t'(dn.v), GAP_OPEN, SCORE_W),
                        sat_add(wide_t'(e_q), GAP_EXTEND, SCORE_W), LO);
        f_nx     = max3(sat_add(wide_t'(up.v), GAP_OPEN, SCORE_W),
                        sat_add(wide_t'(up.f), GAP_EXTEND, SCORE_W), LO);
        m_nx     = sat_add(wide_t'(diag_q), (s_q == up.t) ? MATCH : MISMATCH, SCORE_W);
        floor_v  = (mode_now == SW_LOCAL) ? 32'sd0 : LO;
        h_nx     = max3(m_nx, e_nx, f_nx);
        if (floor_v > h_nx) h_nx = floor_v;
        h_next   = sc_t'(h_nx);
        e_next   = sc_t'(e_nx);
        f_next   = sc_t'(f_nx);
        idle_ef  = local_mode ? sc_t'(0) : sc_t'(LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            e_q         <= '0;
            diag_q      <= '0;
            mode_q      <= SW_LOCAL;
            dn.v        <= '0;
            dn.f        <= '0;
            dn.t        <= '0;
            dn.store_s  <= 1'b0;
            dn.init     <= 1'b0;
        end else begin
            if (up.store_s) s_q <= s_in;
            diag_q     <= up.v;
            dn.t       <= up.t;
            dn.store_s <= up.store_s;
            dn.init    <= up.init;
            if (up.init) begin
                if (rise) mode_q <= mode_of(local_mode);
                dn.v <= h_next;
                e_q  <= e_next;
                dn.f <= f_next;
            end else begin
                dn.v <= '0;
                e_q  <= idle_ef;
                dn.f <= idle_ef;
            end
        end
    end

    sw_best_tracker #(
        .SCORE_W (SCORE_W),
        .POS_W   (POS_W),
        .PE_ID   (PE_ID)
    ) u_best (
        .clk     (clk),
        .rst     (rst),
        .compute (up.init),
        .rise    (rise),
        .h_next  (h_next),
        .up      (up),
        .dn      (dn)
    );
endmodule
